seven_seg_scan: RTL and testbench

SEVEN_SEG_SCAN -- requirements
Module: seven_seg_scan

---
 rtl/seven_seg_pkg.sv | 18 +
 rtl/seven_seg_scan_hex_to_seg.sv | 12 +
 rtl/seven_seg_scan.sv | 106 ++++++++++
 tb/tb_seven_seg_scan.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared constants and segment table for the four-digit seven-segment scanner.
// Segment patterns are active-low {g,f,e,d,c,b,a}.
package seven_seg_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int IDX_W      = $clog2(NUM_DIGITS);

  localparam logic [6:0]            SEG_OFF = 7'h7F;
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = '1;

  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seven_seg_scan_hex_to_seg.sv
// Combinational hex nibble to active-low seven-segment pattern.
// Pure table lookup into the shared package.
module hex_to_seg
  import seven_seg_pkg::*;
(
  input  logic [3:0] i_hex,
  output logic [6:0] o_seg
);

  assign o_seg = SEG_TABLE[i_hex];

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed four-digit seven-segment driver with per-frame snapshot,
// leading-zero blanking and a frame boundary pulse.
module seven_seg_scan
  import seven_seg_pkg::*;
#(
  parameter int REFRESH_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [15:0] digits,
  input  logic [3:0]  dp_in,
  input  logic        blank_lz,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] P_MAX = PW'(REFRESH_DIV - 1);

  logic [PW-1:0]    r_presc;
  logic [IDX_W-1:0] r_idx;
  logic [15:0]      r_snap;
  logic [3:0]       r_dps;
  logic [3:0]       r_an;
  logic [6:0]       r_seg;
  logic             r_dp;
  logic             r_fd;

  logic             w_tick;
  logic             w_wrap;
  logic [IDX_W-1:0] w_idx_nx;
  logic [15:0]      w_snap_nx;
  logic [3:0]       w_dps_nx;
  logic [3:0]       w_nib;
  logic [6:0]       w_seg;
  logic [3:0]       w_an;
  logic             w_hi_zero;
  logic             w_blank;

  assign w_tick    = enable && (r_presc == P_MAX);
  assign w_wrap    = w_tick && (r_idx == IDX_W'(NUM_DIGITS - 1));
  assign w_idx_nx  = r_idx + 1'b1;
  // Outputs decode the next slot from the snapshot it will see.
  assign w_snap_nx = w_wrap ? digits : r_snap;
  assign w_dps_nx  = w_wrap ? dp_in : r_dps;
  assign w_nib     = w_snap_nx[{w_idx_nx, 2'b00} +: 4];
  assign w_an      = ~(4'b0001 << w_idx_nx);

  always_comb begin
    w_hi_zero = 1'b0;
    unique case (w_idx_nx)
      2'd0: w_hi_zero = 1'b0;
      2'd1: w_hi_zero = (w_snap_nx[15:4] == '0);
      2'd2: w_hi_zero = (w_snap_nx[15:8] == '0);
      2'd3: w_hi_zero = (w_snap_nx[15:12] == '0);
    endcase
  end

  assign w_blank = blank_lz && w_hi_zero;

  hex_to_seg u_hex (
    .i_hex (w_nib),
    .o_seg (w_seg)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_presc <= '0;
      r_idx   <= '0;
      r_snap  <= '0;
      r_dps   <= '0;
      r_an    <= AN_OFF;
      r_seg   <= SEG_OFF;
      r_dp    <= 1'b1;
      r_fd    <= 1'b0;
    end else begin
      r_fd <= w_wrap;
      if (enable) begin
        r_presc <= w_tick ? '0 : r_presc + 1'b1;
      end
      if (w_tick) begin
        r_idx  <= w_idx_nx;
        r_snap <= w_snap_nx;
        r_dps  <= w_dps_nx;
        if (w_blank) begin
          r_an  <= AN_OFF;
          r_seg <= SEG_OFF;
          r_dp  <= 1'b1;
        end else begin
          r_an  <= w_an;
          r_seg <= w_seg;
          r_dp  <= ~w_dps_nx[w_idx_nx];
        end
      end
    end
  end

  assign an         = r_an;
  assign seg        = r_seg;
  assign dp         = r_dp;
  assign frame_done = r_fd;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Randomized and directed bench for seven_seg_scan at REFRESH_DIV=4 and 1,
// compared against a slot-level behavioural model.
module tb_seven_seg_scan;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        enable;
  logic        blank_lz;
  logic [15:0] digits;
  logic [3:0]  dp_in;

  logic [3:0] an0, an1;
  logic [6:0] seg0, seg1;
  logic       dp0, dp1;
  logic       fd0, fd1;

  seven_seg_scan #(.REFRESH_DIV(4)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .digits     (digits),
    .dp_in      (dp_in),
    .blank_lz   (blank_lz),
    .an         (an0),
    .seg        (seg0),
    .dp         (dp0),
    .frame_done (fd0)
  );

  seven_seg_scan #(.REFRESH_DIV(1)) u_dut1 (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .digits     (digits),
    .dp_in      (dp_in),
    .blank_lz   (blank_lz),
    .an         (an1),
    .seg        (seg1),
    .dp         (dp1),
    .frame_done (fd1)
  );

  logic [6:0] tbl [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  int divs [2] = '{4, 1};
  int m_p [2];
  int m_idx [2];
  logic [15:0] m_snap [2];
  logic [3:0]  m_dps [2];
  logic [3:0]  m_an [2];
  logic [6:0]  m_seg [2];
  logic        m_dp [2];
  logic        m_fd [2];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic show(input int i);
    int k;
    logic [3:0] one;
    k = m_idx[i];
    one = 4'b0001;
    if (blank_lz && k > 0 && (m_snap[i] >> (4 * k)) == 16'h0) begin
      m_an[i]  = 4'hF;
      m_seg[i] = 7'h7F;
      m_dp[i]  = 1'b1;
    end else begin
      m_an[i]  = ~(one << k);
      m_seg[i] = tbl[(m_snap[i] >> (4 * k)) & 16'hF];
      m_dp[i]  = ~m_dps[i][k];
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      if (!rst) begin
        m_p[i] = 0; m_idx[i] = 0; m_snap[i] = 0; m_dps[i] = 0;
        m_an[i] = 4'hF; m_seg[i] = 7'h7F; m_dp[i] = 1'b1; m_fd[i] = 1'b0;
      end else begin
        m_fd[i] = 1'b0;
        if (enable) begin
          if (m_p[i] == divs[i] - 1) begin
            m_p[i] = 0;
            if (m_idx[i] == 3) begin
              m_snap[i] = digits;
              m_dps[i]  = dp_in;
              m_fd[i]   = 1'b1;
            end
            m_idx[i] = (m_idx[i] + 1) % 4;
            show(i);
          end else begin
            m_p[i]++;
          end
        end
      end
    end
  endtask

  task automatic check_outs();
    check("an",   16'(an0),  16'(m_an[0]));
    check("seg",  16'(seg0), 16'(m_seg[0]));
    check("dp",   16'(dp0),  16'(m_dp[0]));
    check("fd",   16'(fd0),  16'(m_fd[0]));
    check("an_1",  16'(an1),  16'(m_an[1]));
    check("seg_1", 16'(seg1), 16'(m_seg[1]));
    check("dp_1",  16'(dp1),  16'(m_dp[1]));
    check("fd_1",  16'(fd1),  16'(m_fd[1]));
    check("an_onehot", 16'($countones(~an0) <= 1), 16'd1);
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_outs();
    end
  endtask

  initial begin
    rst = 1'b0; enable = 1'b1; blank_lz = 1'b0;
    digits = 16'h1234; dp_in = 4'h0;
    run(2);
    check("rst_an",  16'(an0),  16'hF);
    check("rst_seg", 16'(seg0), 16'h7F);
    check("rst_fd",  16'(fd0),  16'h0);
    rst = 1'b1;
    run(40);
    digits = 16'h0050; blank_lz = 1'b1;
    run(40);
    digits = 16'h1234; blank_lz = 1'b0;
    run(22);
    digits = 16'hABCD;
    run(34);
    enable = 1'b0;
    run(10);
    enable = 1'b1;
    run(9);
    rst = 1'b0;
    run(1);
    check("midrst_an", 16'(an0), 16'hF);
    rst = 1'b1;
    run(20);
    digits = 16'h8888; dp_in = 4'b0100;
    run(40);
    repeat (1500) begin
      for (int n = 0; n < 4; n++)
        digits[4*n +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      dp_in    = 4'($urandom);
      blank_lz = 1'($urandom);
      enable   = ($urandom_range(0, 7) != 0);
      rst      = ($urandom_range(0, 99) != 0);
      run(1);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
